// File: rtl/display_pkg.sv
// Shared types and helpers for the serial display front end.
package display_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, SHIFT, LATCH} state_t;

  // Digit shown in every position when the value is invalid or too large
  localparam logic [3:0] ERR_DIGIT = 4'hE;

  // 10**n, used as the overflow bound for an n-digit display
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift-add-3 step per clk, BIN_W steps per conversion.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int BIN_W    = 14,
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  ovf
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [SR_W-1:0]  sr_q, adj;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q, ovf_q;

  // Add 3 to every BCD digit that is 5 or more before the next shift
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < N_DIGITS; i++)
      if (adj[BIN_W+4*i +: 4] > 4'd4)
        adj[BIN_W+4*i +: 4] = adj[BIN_W+4*i +: 4] + 4'd3;
  end

  // Conversion register; a bit shifted out of the top digit means overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (start) begin
      sr_q   <= {{BCD_W{1'b0}}, bin};
      cnt_q  <= CNT_W'(BIN_W);
      done_q <= 1'b0;
      ovf_q  <= (64'(bin) >= pow10(N_DIGITS));
    end else if (cnt_q != '0) begin
      sr_q  <= {adj[SR_W-2:0], 1'b0};
      ovf_q <= ovf_q | adj[SR_W-1];
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) done_q <= 1'b1;
    end
  end

  assign bcd  = sr_q[SR_W-1 -: BCD_W];
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/serial_display_ctrl.sv
// Display front end: capture, BCD convert, 3-wire serial shift-out, digit latch strobe.
module serial_display_ctrl
  import display_pkg::*;
#(
  parameter int BIN_W     = 14,
  parameter int N_DIGITS  = 4,
  parameter int CLK_DIV   = 256,
  parameter int REFRESH   = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] num,
  input  logic             error,
  input  logic             update,
  output logic             sclk,
  output logic             data_enable,
  output logic             sdo,
  output logic             dclk,
  output logic             busy,
  output logic             overflow
);

  localparam int FRAME_W = 4 * N_DIGITS;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q;
  logic               tick, ref_hit, trig, start;
  logic               pend_q, err_q, sclk_q, de_q, dclk_q, lat_q, ovf_q;
  logic [FRAME_W-1:0] sr_q, frame_d, load_d;
  logic [BIT_W-1:0]   bit_q;
  logic               cv_done, cv_ovf;
  logic [FRAME_W-1:0] cv_bcd;

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  // Free-running clock divider; all frame timing advances on its terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= tick ? '0 : div_q + 1'b1;
  end

  if (REFRESH > 0) begin : g_ref
    localparam int REF_W = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    logic [REF_W-1:0] ref_q;
    assign ref_hit = (ref_q == REF_W'(REFRESH - 1));
    // Periodic refresh timer
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ref_q <= '0;
      else        ref_q <= ref_hit ? '0 : ref_q + 1'b1;
    end
  end else begin : g_noref
    assign ref_hit = 1'b0;
  end

  // Same-cycle update and refresh collapse into a single trigger
  assign trig = update | ref_hit;

  bin2bcd_seq #(.BIN_W(BIN_W), .N_DIGITS(N_DIGITS)) u_conv (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bin  (num),
    .done (cv_done),
    .bcd  (cv_bcd),
    .ovf  (cv_ovf)
  );

  // Frame payload in transmit order: the shifter always sends its MSB first
  always_comb begin
    frame_d = (err_q | cv_ovf) ? {N_DIGITS{ERR_DIGIT}} : cv_bcd;
    load_d  = frame_d;
    if (MSB_FIRST == 0)
      for (int i = 0; i < FRAME_W; i++) load_d[i] = frame_d[FRAME_W-1-i];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and converter start
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE:    if (trig || pend_q) begin
                 state_d = CONVERT;
                 start   = 1'b1;
               end
      CONVERT: if (cv_done && tick) state_d = SHIFT;
      SHIFT:   if (tick && sclk_q && bit_q == BIT_W'(FRAME_W - 1)) state_d = LATCH;
      LATCH:   if (tick && lat_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pending request, serial shifter, latch strobe and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      sr_q   <= '0;
      bit_q  <= '0;
      sclk_q <= 1'b0;
      de_q   <= 1'b0;
      dclk_q <= 1'b0;
      lat_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (state_q != IDLE) begin
        if (trig) pend_q <= 1'b1;
      end else begin
        pend_q <= 1'b0;
      end
      if (start) err_q <= error;
      case (state_q)
        CONVERT: if (state_d == SHIFT) begin
                   sr_q   <= load_d;
                   bit_q  <= '0;
                   sclk_q <= 1'b0;
                   de_q   <= 1'b1;
                   ovf_q  <= cv_ovf;
                 end
        SHIFT:   if (tick) begin
                   if (!sclk_q) begin
                     sclk_q <= 1'b1;
                   end else begin
                     sclk_q <= 1'b0;
                     if (state_d == LATCH) begin
                       de_q   <= 1'b0;
                       dclk_q <= 1'b1;
                       lat_q  <= 1'b0;
                     end else begin
                       sr_q  <= {sr_q[FRAME_W-2:0], 1'b0};
                       bit_q <= bit_q + 1'b1;
                     end
                   end
                 end
        LATCH:   if (tick) begin
                   lat_q <= 1'b1;
                   if (lat_q) dclk_q <= 1'b0;
                 end
        default: ;
      endcase
    end
  end

  assign sclk        = sclk_q;
  assign data_enable = de_q;
  assign sdo         = de_q & sr_q[FRAME_W-1];
  assign dclk        = dclk_q;
  assign busy        = (state_q != IDLE);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_serial_display_ctrl.sv
// Directed bench: three instances (defaults, LS-first, fast refresh) with bus monitors.
module tb_serial_display_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n = 1'b0, rst_n_o = 1'b0;
  logic [13:0] num0 = '0, num1 = '0, num2 = 14'd7;
  logic        err0 = 1'b0, err1 = 1'b0, err2 = 1'b0;
  logic        upd0 = 1'b0, upd1 = 1'b0, upd2 = 1'b0;
  logic        sclk0, de0, sdo0, dclk0, busy0, ovf0;
  logic        sclk1, de1, sdo1, dclk1, busy1, ovf1;
  logic        sclk2, de2, sdo2, dclk2, busy2, ovf2;

  int vecs = 0, errs = 0;

  serial_display_ctrl dut0 (
    .clk(clk), .rst_n(rst0_n), .num(num0), .error(err0), .update(upd0),
    .sclk(sclk0), .data_enable(de0), .sdo(sdo0), .dclk(dclk0), .busy(busy0), .overflow(ovf0));

  serial_display_ctrl #(.CLK_DIV(4), .MSB_FIRST(0)) dut1 (
    .clk(clk), .rst_n(rst_n_o), .num(num1), .error(err1), .update(upd1),
    .sclk(sclk1), .data_enable(de1), .sdo(sdo1), .dclk(dclk1), .busy(busy1), .overflow(ovf1));

  serial_display_ctrl #(.CLK_DIV(1), .REFRESH(200)) dut2 (
    .clk(clk), .rst_n(rst_n_o), .num(num2), .error(err2), .update(upd2),
    .sclk(sclk2), .data_enable(de2), .sdo(sdo2), .dclk(dclk2), .busy(busy2), .overflow(ovf2));

  // Monitors: sample on the falling clk edge, collect bits on sclk rises
  int cyc = 0;
  logic s0p = 1'b0, d0p = 1'b0, b0p = 1'b0, s1p = 1'b0, s2p = 1'b0, b2p = 1'b0;
  int rise0 = 0, dpulse0 = 0, dlen0 = 0, debad0 = 0, frames0 = 0, brise0 = 0, bfall0 = 0;
  int rise1 = 0, rise2 = 0, frames2 = 0, brise2 = 0, brise2_p = 0, srise2 = 0, srise2_p = 0;
  logic [31:0] bits0 = '0, bits1 = '0, bits2 = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    s0p <= sclk0; d0p <= dclk0; b0p <= busy0;
    if (sclk0 && !s0p) begin
      rise0 <= rise0 + 1;
      bits0 <= {bits0[30:0], sdo0};
      if (!de0) debad0 <= debad0 + 1;
    end
    if (dclk0) dlen0 <= dlen0 + 1;
    if (dclk0 && !d0p) dpulse0 <= dpulse0 + 1;
    if (busy0 && !b0p) begin frames0 <= frames0 + 1; brise0 <= cyc; end
    if (!busy0 && b0p) bfall0 <= cyc;
    s1p <= sclk1;
    if (sclk1 && !s1p) begin rise1 <= rise1 + 1; bits1 <= {bits1[30:0], sdo1}; end
    s2p <= sclk2; b2p <= busy2;
    if (sclk2 && !s2p) begin
      rise2 <= rise2 + 1; bits2 <= {bits2[30:0], sdo2};
      srise2_p <= srise2; srise2 <= cyc;
    end
    if (busy2 && !b2p) begin frames2 <= frames2 + 1; brise2_p <= brise2; brise2 <= cyc; end
  end

  task automatic pulse0;
    @(negedge clk); upd0 = 1'b1;
    @(negedge clk); upd0 = 1'b0;
  endtask

  task automatic wait_busy0(input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while (busy0 !== lvl && n < budget) begin @(negedge clk); n++; end
    vecs++;
    if (busy0 !== lvl) begin
      errs++; $display("FAIL %s: busy=%b after %0d cycles, required %b", tag, busy0, n, lvl);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vecs++; if ({sclk0, de0, sdo0, dclk0, busy0, ovf0} !== 6'b0) begin
      errs++; $display("FAIL reset_held: outs=%b required 000000", {sclk0, de0, sdo0, dclk0, busy0, ovf0}); end
    rst0_n = 1'b1; rst_n_o = 1'b1;
    repeat (3) @(negedge clk);
    vecs++; if ({sclk0, de0, sdo0, dclk0, busy0, ovf0} !== 6'b0) begin
      errs++; $display("FAIL reset_idle: outs=%b required 000000", {sclk0, de0, sdo0, dclk0, busy0, ovf0}); end
  endtask

  task automatic test_basic;
    int r, dp, dl;
    num0 = 14'd1234; r = rise0; dp = dpulse0; dl = dlen0;
    pulse0;
    wait_busy0(1'b1, 4, "basic_start");
    wait_busy0(1'b0, 12000, "basic_end");
    @(negedge clk);
    vecs++; if (rise0 - r !== 16) begin errs++; $display("FAIL basic_rises: got %0d required 16", rise0 - r); end
    vecs++; if (bits0[15:0] !== 16'h1234) begin errs++; $display("FAIL basic_stream: got %h required 1234", bits0[15:0]); end
    vecs++; if (dpulse0 - dp !== 1) begin errs++; $display("FAIL basic_dclk_pulses: got %0d required 1", dpulse0 - dp); end
    vecs++; if (dlen0 - dl !== 512) begin errs++; $display("FAIL basic_dclk_len: got %0d required 512", dlen0 - dl); end
    vecs++; if (ovf0 !== 1'b0) begin errs++; $display("FAIL basic_ovf: got %b required 0", ovf0); end
    vecs++; if (debad0 !== 0) begin errs++; $display("FAIL basic_de: %0d rises outside data_enable, required 0", debad0); end
  endtask

  task automatic test_lsb_first;
    int r, n;
    num1 = 14'd1234; r = rise1;
    @(negedge clk); upd1 = 1'b1; @(negedge clk); upd1 = 1'b0;
    n = 0;
    while (busy1 !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
    vecs++; if (busy1 !== 1'b0) begin errs++; $display("FAIL lsb_timeout: busy=%b required 0", busy1); end
    vecs++; if (rise1 - r !== 16) begin errs++; $display("FAIL lsb_rises: got %0d required 16", rise1 - r); end
    vecs++; if (bits1[15:0] !== 16'h2C48) begin errs++; $display("FAIL lsb_stream: got %h required 2c48", bits1[15:0]); end
  endtask

  task automatic test_overflow;
    num0 = 14'd10000; err0 = 1'b0;
    pulse0;
    num0 = 14'd3;
    wait_busy0(1'b0, 12000, "ovf_end");
    @(negedge clk);
    vecs++; if (bits0[15:0] !== 16'hEEEE) begin errs++; $display("FAIL ovf_stream: got %h required eeee", bits0[15:0]); end
    vecs++; if (ovf0 !== 1'b1) begin errs++; $display("FAIL ovf_flag: got %b required 1", ovf0); end
    num0 = 14'd5; err0 = 1'b1;
    pulse0;
    err0 = 1'b0; num0 = 14'd1;
    wait_busy0(1'b0, 12000, "err_end");
    @(negedge clk);
    vecs++; if (bits0[15:0] !== 16'hEEEE) begin errs++; $display("FAIL err_stream: got %h required eeee", bits0[15:0]); end
    vecs++; if (ovf0 !== 1'b0) begin errs++; $display("FAIL err_ovf: got %b required 0", ovf0); end
  endtask

  task automatic test_mid_reset;
    int r, n, dp;
    num0 = 14'd12000; r = rise0; dp = dpulse0;
    pulse0;
    n = 0;
    while (rise0 - r < 7 && n < 12000) begin @(negedge clk); n++; end
    vecs++; if (rise0 - r < 7) begin errs++; $display("FAIL mrst_wait: rises=%0d required 7", rise0 - r); end
    #2 rst0_n = 1'b0;
    #1;
    vecs++; if ({sclk0, de0, sdo0, dclk0, busy0, ovf0} !== 6'b0) begin
      errs++; $display("FAIL mrst_outs: outs=%b required 000000", {sclk0, de0, sdo0, dclk0, busy0, ovf0}); end
    repeat (5) @(negedge clk);
    rst0_n = 1'b1;
    repeat (600) @(negedge clk);
    vecs++; if (dpulse0 !== dp) begin errs++; $display("FAIL mrst_no_dclk: pulses=%0d required %0d", dpulse0, dp); end
    num0 = 14'd9876; r = rise0; dp = dpulse0;
    pulse0;
    wait_busy0(1'b1, 4, "mrst_start");
    wait_busy0(1'b0, 12000, "mrst_end");
    @(negedge clk);
    vecs++; if (rise0 - r !== 16) begin errs++; $display("FAIL mrst_rises: got %0d required 16", rise0 - r); end
    vecs++; if (bits0[15:0] !== 16'h9876) begin errs++; $display("FAIL mrst_stream: got %h required 9876", bits0[15:0]); end
    vecs++; if (dpulse0 - dp !== 1) begin errs++; $display("FAIL mrst_dclk: got %0d required 1", dpulse0 - dp); end
  endtask

  task automatic test_back_to_back;
    int f, r, n, dp;
    num0 = 14'd42; f = frames0; r = rise0; dp = dpulse0;
    pulse0;
    n = 0;
    while (rise0 - r < 2 && n < 12000) begin @(negedge clk); n++; end
    for (int k = 0; k < 3; k++) begin repeat (300) @(negedge clk); pulse0; end
    n = 0;
    while (frames0 - f < 2 && n < 20000) begin @(negedge clk); n++; end
    vecs++; if (brise0 - bfall0 !== 1) begin
      errs++; $display("FAIL b2b_gap: busy gap %0d cycles, required 1", brise0 - bfall0); end
    wait_busy0(1'b0, 12000, "b2b_end");
    repeat (3000) @(negedge clk);
    vecs++; if (frames0 - f !== 2) begin errs++; $display("FAIL b2b_frames: got %0d required 2", frames0 - f); end
    vecs++; if (bits0[15:0] !== 16'h0042) begin errs++; $display("FAIL b2b_stream: got %h required 0042", bits0[15:0]); end
    vecs++; if (dpulse0 - dp !== 2) begin errs++; $display("FAIL b2b_dclk: got %0d required 2", dpulse0 - dp); end
  endtask

  task automatic test_refresh;
    int f, n;
    f = frames2;
    n = 0;
    while (frames2 - f < 3 && n < 1000) begin @(negedge clk); n++; end
    vecs++; if (brise2 - brise2_p !== 200) begin
      errs++; $display("FAIL refresh_period: got %0d required 200", brise2 - brise2_p); end
    n = 0;
    while (busy2 !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    vecs++; if (srise2 - srise2_p !== 2) begin
      errs++; $display("FAIL refresh_sclk: period %0d required 2", srise2 - srise2_p); end
    vecs++; if (bits2[15:0] !== 16'h0007) begin errs++; $display("FAIL refresh_stream: got %h required 0007", bits2[15:0]); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_lsb_first;
    test_overflow;
    test_mid_reset;
    test_back_to_back;
    test_refresh;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
